// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore sequencer for the multicycle MIPS datapath.
// Decodes the IR opcode into per-cycle load enables, mux selects and ALU op class.
// Optional build macro MEM_WAIT_EN: FETCH, MEMRD and MEMWR hold until mem_ready.
// Ports:
//   clk, rst (async, active-low); opcode[5:0] from IR; zero from ALU;
//   mem_ready (only used with MEM_WAIT_EN);
//   pc_en, ir_en, mem_write, reg_write: enables/strobes (forced low in reset);
//   iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]: selects;
//   illegal_op: DECODE pulse on unknown opcode; state[3:0]: current state.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_en,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t r_state;
  logic   w_rdy;

`ifdef MEM_WAIT_EN
  assign w_rdy = mem_ready;
`else
  logic w_unused;
  assign w_rdy    = 1'b1;
  assign w_unused = mem_ready;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (w_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RT:        r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (w_rdy) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (w_rdy) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  logic w_pc_write;
  logic w_branch;
  logic w_ir_en;
  logic w_mem_write;
  logic w_reg_write;
  logic w_illegal;
  logic w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RT, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
      default:                                    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_ir_en     = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    iord        = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    case (r_state)
      S_FETCH: begin
        // IR and PC load only once memory has the instruction
        w_ir_en    = w_rdy;
        w_pc_write = w_rdy;
        alu_src_b  = 2'b01;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        w_illegal = ~w_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        w_branch  = 1'b1;
        pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_write = 1'b1;
        pc_src     = 2'b10;
      end
      default: ;
    endcase
  end

  // rst gates the strobes directly so nothing writes while reset is held
  assign pc_en      = rst & (w_pc_write | (w_branch & zero));
  assign ir_en      = rst & w_ir_en;
  assign mem_write  = rst & w_mem_write;
  assign reg_write  = rst & w_reg_write;
  assign illegal_op = rst & w_illegal;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: vector table, hand sequences and random
// instruction stream against an instruction-level reference model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_en, mem_write, reg_write, iord;
  logic       mem_to_reg, reg_dst, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en),
    .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // {pc_write, ir, mw, rw, iord, m2r, rdst, asa, asb, aop, psrc, ill}
  logic [14:0] base [16];
  bit          brn  [16];

  function automatic logic [14:0] mk(bit pcw, bit ir, bit mw, bit rw,
    bit io, bit m2r, bit rd, bit asa, logic [1:0] asb,
    logic [1:0] aop, logic [1:0] ps);
    return {pcw, ir, mw, rw, io, m2r, rd, asa, asb, aop, ps, 1'b0};
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op == LW || op == SW || op == RT ||
           op == BEQ || op == ADDI || op == JMP;
  endfunction

  function automatic logic [14:0] exp_vec(int st, logic [5:0] op,
    bit z, bit mr);
    logic [14:0] v;
    v = base[st];
    if (WAIT && st == 0 && !mr) v[14:13] = 2'b00;
    v[14] = v[14] | (brn[st] & z);
    v[0]  = (st == 1) && !legal(op);
    return v;
  endfunction

  function automatic logic [14:0] act_vec();
    return {pc_en, ir_en, mem_write, reg_write, iord, mem_to_reg,
            reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
  endfunction

  int q[$];
  task automatic build_seq(input logic [5:0] op);
    case (op)
      LW:      q = {0, 1, 2, 3, 4};
      SW:      q = {0, 1, 2, 5};
      RT:      q = {0, 1, 6, 7};
      BEQ:     q = {0, 1, 8};
      ADDI:    q = {0, 1, 9, 10};
      JMP:     q = {0, 1, 11};
      default: q = {0, 1};
    endcase
  endtask

  typedef struct {
    logic [5:0] op;
    bit         z;
    int         cyc, rw, mw, pce, ir, ill;
  } vec_t;
  vec_t vt [8];

  // Runs one instruction from FETCH; entry/exit at posedge+1
  task automatic run_vec(input vec_t v, input int k);
    int cyc = 0, rw = 0, mw = 0, pce = 0, ir = 0, ill = 0;
    opcode = v.op; zero = v.z; mem_ready = 1'b1;
    do begin
      #4;
      rw += int'(reg_write); mw += int'(mem_write);
      pce += int'(pc_en); ir += int'(ir_en); ill += int'(illegal_op);
      cyc++;
      @(posedge clk); #1;
    end while (state != 4'd0 && cyc < 30);
    chk($sformatf("v%0d_cycles", k), cyc, v.cyc);
    chk($sformatf("v%0d_regwr", k), rw, v.rw);
    chk($sformatf("v%0d_memwr", k), mw, v.mw);
    chk($sformatf("v%0d_pcen", k), pce, v.pce);
    chk($sformatf("v%0d_iren", k), ir, v.ir);
    chk($sformatf("v%0d_illegal", k), ill, v.ill);
  endtask

  task automatic rand_instr(input int k);
    logic [5:0] op;
    logic [5:0] ops [6];
    int idx = 0, guard = 0;
    bit hold;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)]
                                     : 6'($urandom);
    build_seq(op);
    opcode = op;
    while (idx < q.size() && guard < 100) begin
      zero = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      #4;
      chk($sformatf("r%0d_state", k), int'(state), q[idx]);
      chk($sformatf("r%0d_outs", k), int'(act_vec()),
          int'(exp_vec(q[idx], op, zero, mem_ready)));
      hold = WAIT && !mem_ready && (q[idx] == 0 || q[idx] == 3 || q[idx] == 5);
      if (!hold) idx++;
      guard++;
      @(posedge clk); #1;
    end
    chk($sformatf("r%0d_done", k), int'(state), 0);
  endtask

  initial begin
    base[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    base[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    base[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    base[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    base[4]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    base[5]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    base[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
    base[7]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    base[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
    base[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    base[10] = mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    base[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
    for (int i = 12; i < 16; i++) base[i] = '0;
    for (int i = 0; i < 16; i++) brn[i] = (i == 8);

    //        op      z  cyc rw mw pce ir ill
    vt[0] = '{LW,   0, 5, 1, 0, 1, 1, 0};
    vt[1] = '{SW,   0, 4, 0, 1, 1, 1, 0};
    vt[2] = '{RT,   0, 4, 1, 0, 1, 1, 0};
    vt[3] = '{BEQ,  1, 3, 0, 0, 2, 1, 0};
    vt[4] = '{BEQ,  0, 3, 0, 0, 1, 1, 0};
    vt[5] = '{ADDI, 0, 4, 1, 0, 1, 1, 0};
    vt[6] = '{JMP,  0, 3, 0, 0, 2, 1, 0};
    vt[7] = '{6'b111111, 0, 2, 0, 0, 1, 1, 1};

    rst = 1'b0; opcode = LW; zero = 1'b1; mem_ready = 1'b1;
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_strobes", int'({pc_en, ir_en, mem_write, reg_write, illegal_op}), 0);
    chk("rst_asb", int'(alu_src_b), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("first_fetch_ir", int'(ir_en), 1);
    chk("first_fetch_state", int'(state), 0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // lw aborted by reset in MEMWB
    opcode = LW; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 20 && state != 4'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach_wb", int'(state), 4);
    chk("abort_wb_regwr", int'(reg_write), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_regwr", int'(reg_write), 0);
    chk("abort_iren", int'(ir_en), 0);
    @(posedge clk); #1;
    chk("abort_hold_state", int'(state), 0);
    rst = 1'b1;
    #1;
    chk("abort_rel_iren", int'(ir_en), 1);
    chk("abort_rel_pcen", int'(pc_en), 1);

`ifdef MEM_WAIT_EN
    @(posedge clk); #1;
    for (int i = 0; i < 20 && state != 4'd0; i++) begin
      @(posedge clk); #1;
    end
    opcode = 6'b111111;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("wait_state", int'(state), 0);
      chk("wait_iren", int'(ir_en), 0);
      chk("wait_pcen", int'(pc_en), 0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #4;
    chk("ready_iren", int'(ir_en), 1);
    chk("ready_pcen", int'(pc_en), 1);
    @(posedge clk); #1;
    chk("ready_decode", int'(state), 1);
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
    for (int i = 0; i < 20 && state != 4'd0; i++) begin
      @(posedge clk); #1;
    end
`endif

    for (int k = 0; k < 300; k++) rand_instr(k);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
